// File: rtl/digit_serial_add_ctrl_if.sv
// Handshake and adder-digit bundle for the digit-serial add sequencer.
// The sequencer uses the slave view; the environment (producer, consumer, 2-bit adder) uses master.
interface digit_serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin_in;
   logic [1:0]       add_a;
   logic [1:0]       add_b;
   logic             add_cin;
   logic [1:0]       add_sum;
   logic             add_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;

   modport slave (
      input  in_valid, op_a, op_b, cin_in, add_sum, add_carry, out_ready,
      output in_ready, add_a, add_b, add_cin, out_valid, result, cout
   );

   modport master (
      output in_valid, op_a, op_b, cin_in, add_sum, add_carry, out_ready,
      input  in_ready, add_a, add_b, add_cin, out_valid, result, cout
   );
endinterface

// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial add sequencer: feeds an external 2-bit adder one digit per cycle, LSB first,
// chaining the carry, and returns the assembled WIDTH-bit sum with carry-out.
module digit_serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   digit_serial_add_ctrl_if.slave bus
);
   localparam int DIGITS = WIDTH / 2;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] result_r;
   logic             carry_r;
   logic             cout_r;
   logic [CW-1:0]    cnt_r;
   logic             last_s;

   assign last_s = (cnt_r == CW'(DIGITS - 1));

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (bus.in_valid) state_s = RUN;  else state_s = IDLE;
         RUN:     if (last_s)       state_s = DONE; else state_s = RUN;
         DONE:    if (bus.out_ready) state_s = IDLE; else state_s = DONE;
         default: state_s = IDLE;
      endcase
   end

   // Operand shifters, carry chain, digit counter and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= {WIDTH{1'b0}};
         b_sh_r   <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         cout_r   <= 1'b0;
         cnt_r    <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh_r  <= bus.op_a;
                  b_sh_r  <= bus.op_b;
                  carry_r <= bus.cin_in;
                  cnt_r   <= {CW{1'b0}};
               end
            end
            RUN: begin
               // New digit enters at the MSB; after DIGITS shifts it lands in place.
               result_r <= (result_r >> 2) | (WIDTH'(bus.add_sum) << (WIDTH - 2));
               a_sh_r   <= a_sh_r >> 2;
               b_sh_r   <= b_sh_r >> 2;
               carry_r  <= bus.add_carry;
               cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (last_s) begin
                  cout_r <= bus.add_carry;
               end
            end
            DONE: begin
               result_r <= result_r;
            end
            default: begin
               carry_r <= 1'b0;
            end
         endcase
      end
   end

   // Handshake flags and adder digit drive, all decoded from registers
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.add_a     = 2'b00;
      bus.add_b     = 2'b00;
      bus.add_cin   = 1'b0;
      case (state_r)
         IDLE: bus.in_ready = 1'b1;
         RUN: begin
            bus.add_a   = a_sh_r[1:0];
            bus.add_b   = b_sh_r[1:0];
            bus.add_cin = carry_r;
         end
         DONE:    bus.out_valid = 1'b1;
         default: bus.in_ready  = 1'b0;
      endcase
   end

   assign bus.result = result_r;
   assign bus.cout   = cout_r;
endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Directed and random checks of the digit-serial add sequencer, with a behavioural 2-bit adder.
module tb_digit_serial_add_ctrl;
   localparam int WIDTH  = 8;
   localparam int DIGITS = WIDTH / 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_cnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   digit_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   digit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural 2-bit adder, combinational return in the same cycle
   assign {bus.add_carry, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {2'b00, bus.add_cin};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, "_result"},    32'(bus.result),    32'd0);
      check_eq({tag, "_cout"},      32'(bus.cout),      32'd0);
      check_eq({tag, "_add_a"},     32'(bus.add_a),     32'd0);
      check_eq({tag, "_add_b"},     32'(bus.add_b),     32'd0);
      check_eq({tag, "_add_cin"},   32'(bus.add_cin),   32'd0);
   endtask

   // Accept one operand set and wait (bounded) for out_valid, recording add_cin per digit.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                           output logic [3:0] cin_seq, output int lat);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.cin_in   = cin;
      bus.in_valid = 1'b1;
      check_eq("accept_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      lat     = 0;
      cin_seq = 4'b0000;
      while (!bus.out_valid && lat < 20) begin
         if (lat < 4) cin_seq[lat] = bus.add_cin;
         step();
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(DIGITS));
   endtask

   task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_res, input logic exp_cout);
      check_eq({tag, "_result"}, 32'(bus.result), 32'(exp_res));
      check_eq({tag, "_cout"},   32'(bus.cout),   32'(exp_cout));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
      check_eq({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [3:0]       cin_seq;
      int               lat;
      int               prev_t;
      int               wait_n;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      logic [WIDTH:0]   rsum;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op_a      = 8'h00;
      bus.op_b      = 8'h00;
      bus.cin_in    = 1'b0;
      bus.out_ready = 1'b0;
      step();
      step();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      start_op(8'hA5, 8'h3C, 1'b0, cin_seq, lat);
      finish_op("a5_3c", 8'hE1, 1'b0);

      start_op(8'hFF, 8'h01, 1'b0, cin_seq, lat);
      check_eq("ripple_cin_seq", 32'(cin_seq), 32'h0000_000E);
      finish_op("ff_01", 8'h00, 1'b1);

      start_op(8'hFF, 8'h00, 1'b1, cin_seq, lat);
      finish_op("ff_00_c1", 8'h00, 1'b1);
      start_op(8'h00, 8'h00, 1'b1, cin_seq, lat);
      finish_op("00_00_c1", 8'h01, 1'b0);

      // Backpressure in DONE with stray in_valid pulses
      start_op(8'h5A, 8'h6B, 1'b1, cin_seq, lat);
      bus.op_a = 8'h77;
      bus.op_b = 8'h77;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
         step();
         check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check_eq("bp_in_ready",  32'(bus.in_ready),  32'd0);
         check_eq("bp_result",    32'(bus.result),    32'h0000_00C6);
         check_eq("bp_cout",      32'(bus.cout),      32'd0);
      end
      bus.in_valid = 1'b0;
      finish_op("bp_ack", 8'hC6, 1'b0);
      check_eq("bp_result_held", 32'(bus.result), 32'h0000_00C6);

      // Reset while RUN has processed two digits
      bus.op_a     = 8'hFF;
      bus.op_b     = 8'hFF;
      bus.cin_in   = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check_eq("pre_reset_add_a", 32'(bus.add_a), 32'd3);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_run_reset");
      step();
      rst_n = 1'b1;
      step();
      start_op(8'h12, 8'h34, 1'b0, cin_seq, lat);
      finish_op("after_reset", 8'h46, 1'b0);

      // Back-to-back random ops, in_valid held high and out_ready tied 1
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      prev_t        = 0;
      for (int i = 0; i < 1000; i++) begin
         ra   = WIDTH'($urandom);
         rb   = WIDTH'($urandom);
         rc   = 1'($urandom_range(1, 0));
         rsum = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
         bus.op_a   = ra;
         bus.op_b   = rb;
         bus.cin_in = rc;
         wait_n = 0;
         while (!bus.in_ready && wait_n < 20) begin
            step();
            wait_n++;
         end
         check_eq("rnd_ready", 32'(bus.in_ready), 32'd1);
         if (i > 0) check_eq("rnd_spacing", 32'(cyc_cnt - prev_t), 32'd6);
         prev_t = cyc_cnt;
         step();
         wait_n = 0;
         while (!bus.out_valid && wait_n < 20) begin
            step();
            wait_n++;
         end
         check_eq("rnd_result", 32'(bus.result), 32'(rsum[WIDTH-1:0]));
         check_eq("rnd_cout",   32'(bus.cout),   32'(rsum[WIDTH]));
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
